// File: rtl/mandel_pkg.sv
// Shared types and fixed-point constants for the Mandelbrot front end.
package mandel_pkg;

  localparam int COORD_W = 27;  // 4.23 two's complement
  localparam int FRAC_W  = 23;

  localparam logic [COORD_W-1:0] ONE     = 27'h0800000;
  localparam logic [COORD_W-1:0] NEG_ONE = 27'h7800000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mandel_raster_cnt.sv
// Raster position counters: column advances on each accepted pixel, row on column wrap.
module mandel_raster_cnt #(
  parameter int XRES  = 640,
  parameter int YRES  = 480,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             row_wrap,
  output logic             last
);

  localparam logic [CNT_W-1:0] X_MAX = CNT_W'(XRES - 1);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(YRES - 1);

  assign row_wrap = (pix_x == X_MAX);
  assign last     = row_wrap && (pix_y == Y_MAX);

  // clear has priority so a new frame always restarts at the top-left pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_x <= '0;
      pix_y <= '0;
    end else if (clear) begin
      pix_x <= '0;
      pix_y <= '0;
    end else if (advance) begin
      if (row_wrap) begin
        pix_x <= '0;
        pix_y <= (pix_y == Y_MAX) ? '0 : pix_y + 1'b1;
      end else begin
        pix_x <= pix_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mandel_coord_gen.sv
// Raster coordinate generator: turns view parameters into a valid/ready stream of
// complex coordinates, one per accepted handshake, left-to-right, top-to-bottom.
module mandel_coord_gen
  import mandel_pkg::*;
#(
  parameter int WIDTH = COORD_W,
  parameter int XRES  = 640,
  parameter int YRES  = 480,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] x_start,
  input  logic [WIDTH-1:0] y_start,
  input  logic [WIDTH-1:0] step,
  output logic             coord_valid,
  input  logic             coord_ready,
  output logic [WIDTH-1:0] c_re,
  output logic [WIDTH-1:0] c_im,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             last,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] x_lat;
  logic [WIDTH-1:0] step_lat;
  logic             xfer;
  logic             cnt_clear;
  logic             cnt_adv;
  logic             row_wrap;
  logic             cnt_last;

  assign xfer      = coord_valid && coord_ready;
  assign cnt_clear = (state == ST_IDLE) && start;
  // the final pixel does not advance: counters hold until the next start clears them
  assign cnt_adv   = (state == ST_RUN) && xfer && !abort && !cnt_last;
  assign last      = coord_valid && cnt_last;

  mandel_raster_cnt #(
    .XRES  (XRES),
    .YRES  (YRES),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .advance  (cnt_adv),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .row_wrap (row_wrap),
    .last     (cnt_last)
  );

  // frame FSM with parameter latches and the two coordinate accumulators;
  // abort outranks a transfer in RUN, so an aborted last beat never pulses done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      x_lat       <= '0;
      step_lat    <= '0;
      c_re        <= '0;
      c_im        <= '0;
      coord_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_lat       <= x_start;
            step_lat    <= step;
            c_re        <= x_start;
            c_im        <= y_start;
            coord_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            coord_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else if (xfer) begin
            if (cnt_last) begin
              coord_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= ST_DONE;
            end else if (row_wrap) begin
              c_re <= x_lat;
              c_im <= c_im - step_lat;  // imaginary axis decreases down the screen
            end else begin
              c_re <= c_re + step_lat;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          coord_valid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_coord_gen.sv
// Scoreboard bench for mandel_coord_gen on a 4x3 frame.
module tb_mandel_coord_gen;

  localparam int W  = 27;
  localparam int XR = 4;
  localparam int YR = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  x_start = '0;
  logic [W-1:0]  y_start = '0;
  logic [W-1:0]  step = '0;
  logic          coord_valid;
  logic          coord_ready = 1'b1;
  logic [W-1:0]  c_re;
  logic [W-1:0]  c_im;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          last;
  logic          busy;
  logic          done;

  mandel_coord_gen #(.WIDTH(W), .XRES(XR), .YRES(YR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .x_start(x_start), .y_start(y_start), .step(step),
    .coord_valid(coord_valid), .coord_ready(coord_ready),
    .c_re(c_re), .c_im(c_im), .pix_x(pix_x), .pix_y(pix_y),
    .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    int           x;
    int           y;
    logic         lst;
  } beat_t;

  beat_t q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  logic  exp_run = 1'b0;
  logic  pend_done = 1'b0;
  logic  rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: pixel (i,j) = (x0 + i*step, y0 - j*step) modulo 2**W
  task automatic push_frame(input logic [W-1:0] xs, input logic [W-1:0] ys, input logic [W-1:0] st);
    beat_t b;
    for (int j = 0; j < YR; j++)
      for (int i = 0; i < XR; i++) begin
        b.re  = W'(64'(xs) + 64'(i) * 64'(st));
        b.im  = W'(64'(ys) - 64'(j) * 64'(st));
        b.x   = i;
        b.y   = j;
        b.lst = (i == XR - 1) && (j == YR - 1);
        q.push_back(b);
      end
  endtask

  // monitor: compares presented beats to the queue head; a held beat is compared
  // every stalled cycle, so any change under backpressure is caught
  always @(negedge clk) begin
    if (!reset) begin
      chk("done", done, pend_done);
      pend_done = 1'b0;
      chk("busy", busy, exp_run);
      chk("coord_valid", coord_valid, exp_run);
      if (coord_valid) begin
        if (q.size() == 0) begin
          chk("beat_expected", 1, 0);
        end else begin
          chk("c_re", c_re, q[0].re);
          chk("c_im", c_im, q[0].im);
          chk("pix_x", pix_x, q[0].x);
          chk("pix_y", pix_y, q[0].y);
          chk("last", last, q[0].lst);
          if (coord_ready) begin
            if (q[0].lst && !abort) begin
              pend_done = 1'b1;
              exp_run   = 1'b0;
            end
            void'(q.pop_front());
          end
        end
      end
      if (abort && exp_run) begin
        exp_run = 1'b0;
        q.delete();
      end
    end
  end

  task automatic do_start(input logic [W-1:0] xs, input logic [W-1:0] ys, input logic [W-1:0] st,
                          input logic with_abort);
    x_start = xs; y_start = ys; step = st;
    start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    exp_run = 1'b1;
    push_frame(xs, ys, st);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_run || pend_done || q.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      coord_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      n++;
    end
    coord_ready = 1'b1;
    chk({name, "_timeout"}, (n >= 400), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_beat(input int x, input int y);
    int n = 0;
    while (!(coord_valid && pix_x == x && pix_y == y) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_beat_timeout", (n >= 100), 0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, coord_valid, 0);
    chk({name, "_c_re"}, c_re, 0);
    chk({name, "_c_im"}, c_im, 0);
    chk({name, "_pix_x"}, pix_x, 0);
    chk({name, "_pix_y"}, pix_y, 0);
    chk({name, "_last"}, last, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // 1/2: straight frame, row wrap, last and done timing
    do_start(27'h7800000, 27'h0800000, 27'h0200000, 1'b0);
    chk("first_latency_valid", coord_valid, 1);
    wait_idle("frame1");

    // abort while idle is ignored
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 3: backpressure at (2,1)
    do_start(27'h7800000, 27'h0800000, 27'h0200000, 1'b0);
    wait_beat(2, 1);
    coord_ready = 1'b0;
    repeat (5) @(posedge clk); #1;
    coord_ready = 1'b1;
    wait_idle("backpressure");

    // 4: stray start and parameter change mid-frame
    do_start(27'h7800000, 27'h0800000, 27'h0200000, 1'b0);
    wait_beat(1, 1);
    start = 1'b1; x_start = '0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("restart_ignored");

    // 5: abort at (2,0), then a fresh frame
    do_start(27'h7800000, 27'h0800000, 27'h0200000, 1'b0);
    wait_beat(2, 0);
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    repeat (3) @(posedge clk); #1;
    do_start(27'h7800000, 27'h0800000, 27'h0200000, 1'b0);
    wait_idle("after_abort");

    // abort coinciding with the last transfer: no done
    do_start(27'h0100000, 27'h7F00000, 27'h0010000, 1'b0);
    wait_beat(3, 2);
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    repeat (3) @(posedge clk); #1;

    // start and abort together in idle: start wins
    do_start(27'h0000000, 27'h0000000, 27'h0400000, 1'b1);
    wait_idle("start_abort_idle");

    // 6: async reset mid-frame
    do_start(27'h7800000, 27'h0800000, 27'h0200000, 1'b0);
    wait_beat(1, 2);
    reset = 1'b1;
    #1;
    chk_zero("midframe_reset");
    q.delete(); exp_run = 1'b0; pend_done = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // modulo wrap of the real accumulator
    rnd_ready = 1'b1;
    do_start(27'h3FFFFFF, 27'h0000000, 27'h0000001, 1'b0);
    wait_idle("wrap");

    // randomized frames under random backpressure
    for (int k = 0; k < 6; k++) begin
      do_start(W'($urandom), W'($urandom), W'($urandom), 1'b0);
      wait_idle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
